// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
// Benches pick up the default WIDTH/CHUNK from here.
package pipe_adder_pkg;

   localparam int unsigned PA_WIDTH = 8;
   localparam int unsigned PA_CHUNK = 2;

   function automatic int unsigned pa_stages(
      input int unsigned w,
      input int unsigned c
   );
      return w / c;
   endfunction

   function automatic bit pa_legal(
      input int unsigned w,
      input int unsigned c
   );
      return (c != 0) && (c <= w) && ((w % c) == 0);
   endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// One CHUNK-bit slice of the carry chain.
// Holds registered sum, carry-out and valid, all advancing on adv_i.
module pipe_adder_stage
   import pipe_adder_pkg::*;
#(
   parameter int unsigned CHUNK = PA_CHUNK
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             adv_i,
   input  logic             v_i,
   input  logic             cin_i,
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   output logic             v_o,
   output logic [CHUNK-1:0] s_o,
   output logic             c_o
);

   logic [CHUNK:0]   sum_d;
   logic             v_q;
   logic [CHUNK-1:0] s_q;
   logic             c_q;

   assign sum_d = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};

   // Data loads only with a live beat so bubbles leave the last value intact.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         v_q <= 1'b0;
         s_q <= '0;
         c_q <= 1'b0;
      end else if (adv_i) begin
         v_q <= v_i;
         if (v_i) begin
            {c_q, s_q} <= sum_d;
         end
      end
   end

   assign v_o = v_q;
   assign s_o = s_q;
   assign c_o = c_q;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/sub, one CHUNK slice per stage, valid/ready flow.
// Define PIPE_ADDER_SAT_EN to clamp the result on signed overflow.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int unsigned WIDTH = PA_WIDTH,
   parameter int unsigned CHUNK = PA_CHUNK
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out,
   output logic             ovf
);

   localparam int unsigned STAGES = pa_stages(WIDTH, CHUNK);

   if (!pa_legal(WIDTH, CHUNK)) begin : g_bad_cfg
      $error("pipe_adder: WIDTH must be a multiple of CHUNK");
   end

   logic             adv;
   logic [WIDTH-1:0] a_src   [STAGES];
   logic [WIDTH-1:0] b_src   [STAGES];
   logic             c_src   [STAGES];
   logic             v_src   [STAGES];
   logic             sub_src [STAGES];
   logic [CHUNK-1:0] s_w     [STAGES];
   logic             c_w     [STAGES];
   logic             v_w     [STAGES];
   logic [WIDTH-1:0] ax_q    [STAGES];
   logic [WIDTH-1:0] bx_q    [STAGES];
   logic             sub_q   [STAGES];
   logic [WIDTH-1:0] fin;
   logic [WIDTH-1:0] res;
   logic             ovf_w;
   logic             a_msb;

   assign adv      = !out_valid | out_ready;
   assign in_ready = adv;

   // ax carries done sums below slice k and raw A above it.
   always_comb begin
      a_src[0]   = in0;
      b_src[0]   = in1 ^ {WIDTH{in_sub}};
      c_src[0]   = in_sub;
      v_src[0]   = in_valid;
      sub_src[0] = in_sub;
      for (int k = 1; k < STAGES; k++) begin
         a_src[k] = ax_q[k-1];
         a_src[k][(k-1)*CHUNK +: CHUNK] = s_w[k-1];
         b_src[k]   = bx_q[k-1];
         c_src[k]   = c_w[k-1];
         v_src[k]   = v_w[k-1];
         sub_src[k] = sub_q[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      pipe_adder_stage #(
         .CHUNK (CHUNK)
      ) u_stage (
         .clk_i  (i_clk),
         .rst_ni (i_rst_n),
         .adv_i  (adv),
         .v_i    (v_src[k]),
         .cin_i  (c_src[k]),
         .a_i    (a_src[k][k*CHUNK +: CHUNK]),
         .b_i    (b_src[k][k*CHUNK +: CHUNK]),
         .v_o    (v_w[k]),
         .s_o    (s_w[k]),
         .c_o    (c_w[k])
      );
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            ax_q[k]  <= '0;
            bx_q[k]  <= '0;
            sub_q[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (adv && v_src[k]) begin
               ax_q[k]  <= a_src[k];
               bx_q[k]  <= b_src[k];
               sub_q[k] <= sub_src[k];
            end
         end
      end
   end

   always_comb begin
      fin = ax_q[STAGES-1];
      fin[(STAGES-1)*CHUNK +: CHUNK] = s_w[STAGES-1];
   end

   // Carry into MSB is recovered from the MSB operand and sum bits.
   assign a_msb = ax_q[STAGES-1][WIDTH-1];
   assign ovf_w = a_msb ^ bx_q[STAGES-1][WIDTH-1]
                ^ fin[WIDTH-1] ^ c_w[STAGES-1];

`ifdef PIPE_ADDER_SAT_EN
   assign res = ovf_w ? {a_msb, {(WIDTH-1){~a_msb}}} : fin;
`else
   assign res = fin;
`endif

   assign out       = {c_w[STAGES-1] ^ sub_q[STAGES-1], res};
   assign ovf       = ovf_w;
   assign out_valid = v_w[STAGES-1];

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: queue scoreboard over an arithmetic model,
// directed corner beats, backpressure, reset and a CHUNK==WIDTH build.
module tb_pipe_adder;
   import pipe_adder_pkg::*;

   localparam int W = PA_WIDTH;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in0 = '0;
   logic [W-1:0] in1 = '0;
   logic         in_sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W:0]   out;
   logic         ovf;

   logic         in_valid8 = 1'b0;
   logic         in_ready8;
   logic [7:0]   a8 = '0;
   logic [7:0]   b8 = '0;
   logic         in_sub8 = 1'b0;
   logic         out_valid8;
   logic         out_ready8 = 1'b1;
   logic [8:0]   out8;
   logic         ovf8;

   logic [9:0]   q[$];
   logic [9:0]   e;
   logic [9:0]   snap_q;
   logic         stall_q = 1'b0;
   int           checks = 0;
   int           passed = 0;
   int           run = 0;
   int           max_run = 0;

`ifdef PIPE_ADDER_SAT_EN
   localparam logic [9:0] E_ADD_OVF = 10'h27F;
   localparam logic [9:0] E_SUB_OVF = 10'h280;
`else
   localparam logic [9:0] E_ADD_OVF = 10'h280;
   localparam logic [9:0] E_SUB_OVF = 10'h27F;
`endif

   always #5 clk = ~clk;

   pipe_adder #(.WIDTH(8), .CHUNK(2)) u_dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in0       (in0),
      .in1       (in1),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .ovf       (ovf)
   );

   pipe_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .in0       (a8),
      .in1       (b8),
      .in_sub    (in_sub8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .out       (out8),
      .ovf       (ovf8)
   );

   // Result = {ovf, borrow/carry, low byte} from integer arithmetic.
   function automatic logic [9:0] model(
      input logic [7:0] a,
      input logic [7:0] b,
      input logic       sub
   );
      int         sa;
      int         sb;
      int         r;
      int         u;
      logic       v;
      logic       c;
      logic [7:0] low;
      sa  = int'($signed(a));
      sb  = int'($signed(b));
      r   = sub ? sa - sb : sa + sb;
      u   = sub ? int'(a) - int'(b) : int'(a) + int'(b);
      v   = (r > 127) || (r < -128);
      c   = sub ? (a < b) : (u > 255);
      low = 8'(u);
`ifdef PIPE_ADDER_SAT_EN
      if (v) low = (r > 0) ? 8'h7F : 8'h80;
`endif
      return {v, c, low};
   endfunction

   task automatic chk(
      input string       name,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         stall_q = 1'b0;
         run = 0;
      end else begin
         if (stall_q) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'({ovf, out}), 32'(snap_q));
         end
         if (out_valid) begin
            run++;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("spurious_out", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               chk("result", 32'({ovf, out}), 32'(e));
            end
         end
         if (in_valid && in_ready) q.push_back(model(in0, in1, in_sub));
         stall_q = out_valid && !out_ready;
         snap_q  = {ovf, out};
      end
   end

   task automatic drive_beat(
      input logic [7:0] a,
      input logic [7:0] b,
      input logic       s
   );
      bit acc;
      int n;
      n = 0;
      in0 = a;
      in1 = b;
      in_sub = s;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 100);
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic directed(
      input string      name,
      input logic [7:0] a,
      input logic [7:0] b,
      input logic       s,
      input logic [9:0] exp
   );
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drive_beat(a, b, s);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk({name, "_early"}, 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk({name, "_valid"}, 32'(out_valid), 32'd1);
      chk(name, 32'({ovf, out}), 32'(exp));
      @(posedge clk);
      #1;
      chk({name, "_once"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_out", 32'({ovf, out}), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      directed("add_ff_01", 8'hFF, 8'h01, 1'b0, 10'h100);
      directed("add_7f_01", 8'h7F, 8'h01, 1'b0, E_ADD_OVF);
      directed("sub_05_07", 8'h05, 8'h07, 1'b1, 10'h1FE);
      directed("sub_80_01", 8'h80, 8'h01, 1'b1, E_SUB_OVF);

      // Back-to-back beats must come out as one unbroken run.
      max_run = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive_beat(8'($urandom), 8'($urandom), 1'($urandom));
      end
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("b2b_run", 32'(max_run), 32'd10);
      chk("b2b_drained", 32'(q.size()), 32'd0);

      out_ready = 1'b0;
      fork
         begin : bp_drv
            for (int i = 0; i < 6; i++) begin
               drive_beat(8'($urandom), 8'($urandom), 1'($urandom));
            end
            in_valid = 1'b0;
         end
         begin : bp_mon
            int         n;
            logic [9:0] sn;
            n = 0;
            do begin
               @(posedge clk);
               #1;
               n++;
            end while (!out_valid && n < 50);
            chk("bp_seen", 32'(out_valid), 32'd1);
            sn = {ovf, out};
            repeat (3) begin
               @(posedge clk);
               #1;
               chk("bp_in_ready", 32'(in_ready), 32'd0);
               chk("bp_stable", 32'({ovf, out}), 32'(sn));
            end
            out_ready = 1'b1;
         end
      join
      repeat (12) @(posedge clk);
      #1;
      chk("bp_drained", 32'(q.size()), 32'd0);

      // Reset with beats in flight and a result on the output.
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive_beat(8'($urandom), 8'($urandom), 1'($urandom));
      end
      in_valid = 1'b0;
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_out", 32'({ovf, out}), 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      begin : post_rst
         bit seen;
         seen = 1'b0;
         repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid || out != '0) seen = 1'b1;
         end
         chk("post_rst_quiet", 32'(seen), 32'd0);
      end

      @(posedge clk);
      #1;
      a8 = 8'h12;
      b8 = 8'h34;
      in_sub8 = 1'b0;
      in_valid8 = 1'b1;
      chk("c8_in_ready", 32'(in_ready8), 32'd1);
      @(posedge clk);
      #1;
      in_valid8 = 1'b0;
      chk("c8_valid", 32'(out_valid8), 32'd1);
      chk("c8_result", 32'({ovf8, out8}), 32'h046);
      @(posedge clk);
      #1;
      chk("c8_once", 32'(out_valid8), 32'd0);

      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom % 4) != 0;
         in0       = 8'($urandom);
         in1       = 8'($urandom);
         in_sub    = 1'($urandom);
         out_ready = ($urandom % 3) != 0;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("rand_drained", 32'(q.size()), 32'd0);
      chk("rand_idle", 32'(out_valid), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined two-operand adder/subtractor; next generation of the team's registered 2-bit adder.
- Splits a WIDTH-bit carry chain into CHUNK-bit slices, with one register stage per slice, so it closes timing at high clock rates.
- Adds valid/ready flow control with backpressure, a subtract mode and signed-overflow reporting.
- Sits between operand sources and result consumers on the fabric clock domain.

Parameters:
- WIDTH, 8, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 2, bits summed per pipeline stage; STAGES = WIDTH/CHUNK.

Ports:
- i_clk  input  1  fabric clock; all logic is on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat is valid.
- in_ready  output  1  block accepts a beat this cycle.
- in0  input  WIDTH  operand A (unsigned or two's complement).
- in1  input  WIDTH  operand B.
- in_sub  input  1  1: compute in0-in1; 0: compute in0+in1.
- out_valid  output  1  result beat is valid.
- out_ready  input  1  consumer accepts the result.
- out  output  WIDTH+1  result; out[WIDTH] is carry (add) or borrow (sub).
- ovf  output  1  signed overflow of out[WIDTH-1:0].

Behaviour:
- Reset, asynchronous, active-low:
  - out_valid=0, out=0, ovf=0.
  - All stage valid bits and data registers are cleared.
  - Reset mid-operation discards all in-flight beats; nothing is output after release until new beats are accepted.
- Advance enable: adv = !out_valid | out_ready. in_ready = adv, combinational, with no dependency on in_valid.
- Handshakes:
  - A beat is accepted when in_valid & in_ready.
  - A beat is delivered when out_valid & out_ready.
  - While adv=0, every pipeline register holds, so out, ovf and out_valid stay stable.
- Latency: exactly STAGES cycles from acceptance to out_valid, with no backpressure applied.
- Throughput: one beat per cycle.
- Bubbles (in_valid=0 while adv=1) propagate as stage valid=0. Data in invalid stages is don't-care, but out must hold its last value while out_valid=0.
- Stage k (k = 0..STAGES-1):
  - Adds slice k of in0 and of (in1 XOR {WIDTH{in_sub}}), plus carry-in.
  - Carry-in of stage 0 is in_sub. Carry-in of stage k>0 is the registered carry-out of stage k-1.
  - Stage k outputs a CHUNK-bit sum slice and a carry register.
- Skew/deskew:
  - Unconsumed upper operand slices travel forward through skew registers.
  - Completed lower sum slices travel forward through deskew registers.
  - All slices of one beat emerge together.
  - in_sub travels with its beat.
- Final carry C: out[WIDTH] = C XOR sub_of_beat, so it is 1 on unsigned borrow.
- ovf = carry into the MSB XOR carry out of the MSB, evaluated in the last stage.
- Simultaneous accept and deliver in the same cycle is legal and required for full throughput.
- CHUNK == WIDTH is legal: a single stage with latency 1.

Optional Feature:
- Macro: PIPE_ADDER_SAT_EN.
- Defined:
  - In the last stage, when ovf=1, out[WIDTH-1:0] is clamped to 0x7F..F if the true result is positive, or 0x80..0 if negative.
  - ovf still reports 1.
  - out[WIDTH] is unchanged.
- Undefined: out[WIDTH-1:0] wraps modulo 2^WIDTH. No saturation logic is synthesised.

Decomposition:
- Package pipe_adder_pkg holds:
  - the STAGES derivation (WIDTH/CHUNK);
  - an elaboration check that WIDTH % CHUNK == 0;
  - the default WIDTH and CHUNK constants shared with benches.
- One sub-module, pipe_adder_stage: CHUNK-bit add with carry-in, registered sum/carry/valid and adv-gated enable.
- The top generates STAGES instances plus the skew/deskew registers.

Test Plan (WIDTH=8, CHUNK=2, latency 4 unless stated):
- Add 0xFF+0x01, in_sub=0 -> 4 cycles later out=0x100, ovf=0, out_valid for one cycle with out_ready=1.
- Add 0x7F+0x01 -> out=0x080, ovf=1. With PIPE_ADDER_SAT_EN: out=0x07F, ovf=1.
- Sub 0x05-0x07 -> out=0x1FE (borrow=1), ovf=0. Sub 0x80-0x01 -> out=0x07F, ovf=1.
- Back-to-back: 10 random beats on consecutive cycles with out_ready=1 -> 10 results on consecutive cycles, in order, matching the reference model.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> in_ready=0, out/ovf stable; release -> no loss or duplication.
- Drop i_rst_n for one cycle with 3 beats in flight -> out_valid=0 and out=0 immediately (asynchronous); no stale results after release. Also run CHUNK=8: 0x12+0x34 -> out=0x046 after 1 cycle.
